// File: rtl/sampler_trig_ctrl.sv
// rtl/sampler_trig_ctrl.sv - sampler start/stop controller with link gating, pattern trigger and length limit
module sampler_trig_ctrl #(
  parameter int CHANNEL     = 16,
  parameter int DATA_BITS   = 16,
  parameter int SEL_BITS    = 4,
  parameter int COUNT_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           sample_clk,
  input  logic                           sample_clk_rstn,
  input  logic                           start_sample,
  input  logic                           stop_sample,
  input  logic                           link_ready,
  input  logic [1:0]                     mode,
  input  logic [SEL_BITS-1:0]            trig_sel,
  input  logic [DATA_BITS-1:0]           trig_mask,
  input  logic [DATA_BITS-1:0]           trig_value,
  input  logic                           trig_edge,
  input  logic [COUNT_BITS-1:0]          capture_len,
  input  logic [DATA_BITS*CHANNEL-1:0]   data_in,
  output logic                           running,
  output logic                           begin_of_sample,
  output logic                           trig_seen,
  output logic                           done,
  output logic [COUNT_BITS-1:0]          sample_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINK = 3'd1,
    WAIT_TRIG = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [SEL_BITS:0] CHAN_L = (SEL_BITS+1)'(CHANNEL);

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    link_sync;
  logic [1:0]              mode_q;
  logic [COUNT_BITS-1:0]   len_q;
  logic [DATA_BITS-1:0]    word;
  logic                    sel_valid;
  logic                    match_d, match_q, match_p;
  logic                    hit;
  logic                    arm;
  logic                    len_hit;

  always_ff @(posedge sample_clk or negedge sample_clk_rstn) begin
    if (!sample_clk_rstn) sync_q <= '0;
    else                  sync_q <= {sync_q[SYNC_STAGES-2:0], link_ready};
  end
  assign link_sync = sync_q[SYNC_STAGES-1];

  // Out-of-range selects leave word at zero; sel_valid suppresses the match.
  always_comb begin
    word = '0;
    for (int k = 0; k < CHANNEL; k++) begin
      if (trig_sel == SEL_BITS'(k)) word = data_in[k*DATA_BITS +: DATA_BITS];
    end
  end
  assign sel_valid = ({1'b0, trig_sel} < CHAN_L);
  assign match_d   = sel_valid && (((word ^ trig_value) & trig_mask) == '0);

  always_ff @(posedge sample_clk or negedge sample_clk_rstn) begin
    if (!sample_clk_rstn) begin
      match_q <= 1'b0;
      match_p <= 1'b0;
    end else begin
      match_q <= match_d;
      match_p <= match_q;
    end
  end
  assign hit = trig_edge ? (match_q && !match_p) : match_q;

  assign arm     = ((state == IDLE) || (state == DONE)) && start_sample && !stop_sample;
  assign len_hit = mode_q[1] && (len_q != '0) && (sample_count == len_q - COUNT_BITS'(1));

  always_ff @(posedge sample_clk or negedge sample_clk_rstn) begin
    if (!sample_clk_rstn) state <= IDLE;
    else                  state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (stop_sample) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      if (start_sample) state_next = WAIT_LINK;
        WAIT_LINK: if (link_sync)    state_next = mode_q[0] ? WAIT_TRIG : RUN;
        WAIT_TRIG: if (hit)          state_next = RUN;
        RUN:       if (len_hit)      state_next = DONE;
        DONE:      if (start_sample) state_next = WAIT_LINK;
        default:                     state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    running         = (state == RUN);
    begin_of_sample = (state == WAIT_LINK) || (state == WAIT_TRIG);
    done            = (state == DONE);
  end

  // Run configuration is frozen at arm time so mid-capture input changes are ignored.
  always_ff @(posedge sample_clk or negedge sample_clk_rstn) begin
    if (!sample_clk_rstn) begin
      mode_q       <= '0;
      len_q        <= '0;
      sample_count <= '0;
      trig_seen    <= 1'b0;
    end else if (arm) begin
      mode_q       <= mode;
      len_q        <= capture_len;
      sample_count <= '0;
      trig_seen    <= 1'b0;
    end else begin
      if ((state == RUN) && (sample_count != '1))
        sample_count <= sample_count + COUNT_BITS'(1);
      if ((state == WAIT_TRIG) && (state_next == RUN))
        trig_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sampler_trig_ctrl.sv
// tb/tb_sampler_trig_ctrl.sv - self-checking bench for sampler_trig_ctrl
module tb_sampler_trig_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_sample = 1'b0;
  logic         stop_sample = 1'b0;
  logic         link_ready = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic [4:0]   trig_sel = 5'd3;
  logic [15:0]  trig_mask = 16'h00FF;
  logic [15:0]  trig_value = 16'h0042;
  logic         trig_edge = 1'b0;
  logic [31:0]  capture_len = 32'd0;
  logic [255:0] data_in = '0;
  logic         running, begin_of_sample, trig_seen, done;
  logic [31:0]  sample_count;

  int checks = 0;
  int failures = 0;

  sampler_trig_ctrl #(.CHANNEL(16), .DATA_BITS(16), .SEL_BITS(5), .COUNT_BITS(32), .SYNC_STAGES(2)) dut (
    .sample_clk(clk), .sample_clk_rstn(rst_n), .start_sample(start_sample), .stop_sample(stop_sample),
    .link_ready(link_ready), .mode(mode), .trig_sel(trig_sel), .trig_mask(trig_mask),
    .trig_value(trig_value), .trig_edge(trig_edge), .capture_len(capture_len), .data_in(data_in),
    .running(running), .begin_of_sample(begin_of_sample), .trig_seen(trig_seen), .done(done),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, stop;
    logic [1:0]  mode;
    logic [31:0] len;
    logic [15:0] mask, word;
    logic        run, bos, seen, dn;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sp, logic [1:0] md, logic [31:0] ln, logic [15:0] mk_, logic [15:0] wd,
                              logic r, logic b, logic s, logic d, logic [31:0] c);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.len = ln; v.mask = mk_; v.word = wd;
    v.run = r; v.bos = b; v.seen = s; v.dn = d; v.cnt = c;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_word(logic [15:0] w);
    data_in = '0;
    data_in[3*16 +: 16] = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Free run, level trigger, length limit and priority cases, one row per clock edge.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,16'h00FF,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,16'h00FF,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,16'h00FF,0, 1,0,0,0,0));
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0,0,0,0,16'h00FF,0, 1,0,0,0,32'(i)));
    tbl.push_back(mk(0,1,0,0,16'h00FF,0, 0,0,0,0,10));
    tbl.push_back(mk(0,0,0,0,16'h00FF,0, 0,0,0,0,10));
    tbl.push_back(mk(1,0,1,0,16'h00FF,0,       0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,16'h00FF,0,       0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,16'h00FF,16'hAB42, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,16'h00FF,16'hAB42, 1,0,1,0,0));
    tbl.push_back(mk(0,1,1,0,16'h00FF,16'hAB42, 0,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,16'h00FF,0,       0,0,1,0,1));
    tbl.push_back(mk(1,0,3,5,16'h0000,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,3,5,16'h0000,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,3,5,16'h0000,0, 1,0,1,0,0));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(0,0,0,0,16'h0000,0, 1,0,1,0,32'(i)));
    tbl.push_back(mk(0,0,0,0,16'h0000,0, 0,0,1,1,5));
    tbl.push_back(mk(0,0,0,0,16'h0000,0, 0,0,1,1,5));
    tbl.push_back(mk(1,0,3,5,16'h0000,0, 0,1,0,0,0));
    tbl.push_back(mk(1,1,3,5,16'h0000,0, 0,0,0,0,0));
    tbl.push_back(mk(1,1,3,5,16'h0000,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,3,2,16'h0000,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,3,2,16'h0000,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,3,2,16'h0000,0, 1,0,1,0,0));
    tbl.push_back(mk(0,0,3,2,16'h0000,0, 1,0,1,0,1));
    tbl.push_back(mk(0,0,3,2,16'h0000,0, 0,0,1,1,2));
    tbl.push_back(mk(1,1,3,2,16'h0000,0, 0,0,1,0,2));

    #12;
    chk("reset_running", running, 0);
    chk("reset_bos", begin_of_sample, 0);
    chk("reset_count", sample_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    foreach (tbl[i]) begin
      start_sample = tbl[i].start; stop_sample = tbl[i].stop; mode = tbl[i].mode;
      capture_len = tbl[i].len; trig_mask = tbl[i].mask; set_word(tbl[i].word);
      tick();
      chk($sformatf("row%0d_running", i), running, tbl[i].run);
      chk($sformatf("row%0d_bos", i), begin_of_sample, tbl[i].bos);
      chk($sformatf("row%0d_seen", i), trig_seen, tbl[i].seen);
      chk($sformatf("row%0d_done", i), done, tbl[i].dn);
      chk($sformatf("row%0d_count", i), sample_count, tbl[i].cnt);
    end

    // Link gating: armed with link down waits indefinitely, then RUN three edges after link rises.
    start_sample = 0; stop_sample = 0; mode = 0; trig_mask = 16'h00FF; set_word(0);
    link_ready = 0;
    repeat (3) tick();
    start_sample = 1;
    tick();
    start_sample = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("gate_bos", begin_of_sample, 1);
      chk("gate_running", running, 0);
    end
    link_ready = 1;
    tick(); chk("gate_edge1", running, 0);
    tick(); chk("gate_edge2", running, 0);
    tick(); chk("gate_edge3", running, 1);
    stop_sample = 1; tick(); stop_sample = 0;
    chk("gate_stop", running, 0);

    // Out-of-range channel select never triggers.
    trig_sel = 5'd16; mode = 1; set_word(16'hAB42);
    start_sample = 1; tick(); start_sample = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sel16_running", running, 0);
    end
    chk("sel16_bos", begin_of_sample, 1);
    stop_sample = 1; tick(); stop_sample = 0;

    // Edge trigger: a match already present at arm does not fire; a restored match does.
    trig_sel = 5'd3; trig_edge = 1;
    repeat (3) tick();
    start_sample = 1; tick(); start_sample = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("edge_hold", running, 0);
    end
    set_word(0);
    repeat (2) tick();
    chk("edge_drop", running, 0);
    set_word(16'hAB42);
    tick(); chk("edge_r1", running, 0);
    tick(); chk("edge_r2", running, 1);
    chk("edge_seen", trig_seen, 1);
    stop_sample = 1; tick(); stop_sample = 0;
    trig_edge = 0;

    // Asynchronous reset mid-RUN clears outputs without waiting for a clock edge.
    mode = 0;
    start_sample = 1; tick(); start_sample = 0;
    repeat (4) tick();
    chk("pre_reset_running", running, 1);
    chk("pre_reset_count", sample_count, 3);
    #2;
    rst_n = 0;
    #1;
    chk("async_running", running, 0);
    chk("async_count", sample_count, 0);
    chk("async_seen", trig_seen, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_reset_idle", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
